axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- AXI4-Lite master that turns a simple command stream into single AXI4-Lite write or read transactions.
- Returns one response per command on a response stream.
- It is the initiator end of the config slave interface used by our control blocks (e.g. mindy_core_ctl).
- Used by on-chip sequencers and test benches to program and read back register maps without hand-driving the five AXI channels.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles a transaction may wait on the bus before the stall flag asserts; 0 disables the flag.
- AXI_PROT, 3'b000: constant driven on AWPROT/ARPROT.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  0 OKAY, 2 SLVERR, 3 DECERR
- stall  out  1  current transaction has waited at least TIMEOUT_CYCLES
- M_AXI_AWADDR/AWVALID/AWREADY/AWPROT  32/1/1/3  write-address channel, master side
- M_AXI_WDATA/WSTRB/WVALID/WREADY  32/4/1/1  write-data channel
- M_AXI_BRESP/BVALID/BREADY  2/1/1  write-response channel
- M_AXI_ARADDR/ARVALID/ARREADY/ARPROT  32/1/1/3  read-address channel
- M_AXI_RDATA/RRESP/RVALID/RREADY  32/2/1/1  read-data channel

Behaviour:
- Reset values: all VALID and READY outputs 0, cmd_ready 0, rsp_valid 0, rsp_rdata 0, rsp_resp 0, rsp_write 0, stall 0, state IDLE.
- All outputs are registered. WSTRB is constant 4'hF.

FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch the command.
  - If cmd_addr[1:0] != 0: no bus activity; go to RESP with rsp_resp = SLVERR and rsp_rdata = 0.
  - Write: assert AWVALID and WVALID in the same next cycle; go to WR_ADDR_DATA.
  - Read: assert ARVALID; go to RD_ADDR.
- WR_ADDR_DATA:
  - AW and W handshake independently; each VALID drops the cycle after its own READY.
  - Either order, or simultaneous, is legal.
  - When both are done, assert BREADY and go to WR_RESP.
  - VALID is never withdrawn before READY.
- WR_RESP: on BVALID & BREADY, capture BRESP, drop BREADY, go to RESP.
- RD_ADDR: on ARREADY, drop ARVALID, assert RREADY, go to RD_DATA.
- RD_DATA: on RVALID & RREADY, capture RDATA and RRESP, drop RREADY, go to RESP.
- RESP:
  - rsp_valid = 1; fields held stable until rsp_ready.
  - On handshake, go to IDLE with cmd_ready = 1 the following cycle.
  - One command in flight maximum.
- Minimum latency: cmd accept to rsp_valid = 3 cycles with a zero-wait slave (write: AW/W cycle, B cycle, RESP).
- Response codes: BRESP/RRESP of 1 (EXOKAY) is passed through unchanged.
- stall:
  - Counter is 32 bits, saturating; cleared on command accept; increments in every non-IDLE, non-RESP state.
  - stall = (counter >= TIMEOUT_CYCLES) while in those states; cleared on entry to RESP.
  - The transaction is never abandoned; stall is status only.
- Reset mid-transaction: all VALID/READY drop the same cycle reset is sampled; the outstanding command is lost and no response is issued.

Decomposition:
- Shared package axil_pkg:
  - resp codes OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3;
  - FSM state encoding;
  - WSTRB_ALL = 4'hF.
- No sub-module; the stall counter is inline.

Test Plan:
- Write addr 0x28, data 0x0040_0000 to mindy_core_ctl, then read 0x28 -> rsp_resp 0 on both, rsp_rdata 0x0040_0000, rsp_write 1 then 0.
- Write addr 0x50 (index 20, unmapped) -> rsp_resp 3, one B handshake seen; read 0x50 -> rsp_resp 3.
- Slave model with AWREADY delayed 5 cycles and WREADY immediate, then the reverse, then both simultaneous -> exactly one AW and one W handshake each, WVALID low after its handshake, rsp_resp 0.
- cmd_addr 0x0000_0006 -> rsp_valid within 2 cycles, rsp_resp 2, no VALID asserted on any AXI channel.
- TIMEOUT_CYCLES = 16, slave withholds RVALID for 40 cycles -> stall rises exactly 16 cycles after ARVALID, stays high, clears on RESP; rsp_rdata equals slave data.
- Hold rsp_ready low for 10 cycles with a response pending -> rsp fields stable and cmd_ready 0 throughout; assert resetn = 0 during WR_RESP -> all AXI VALID/READY and rsp_valid 0 next cycle.

Source files
------------

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes, write strobe and command-master FSM states
package axil_pkg;

   localparam logic [1:0] OKAY   = 2'd0;
   localparam logic [1:0] EXOKAY = 2'd1;
   localparam logic [1:0] SLVERR = 2'd2;
   localparam logic [1:0] DECERR = 2'd3;

   localparam logic [3:0] WSTRB_ALL = 4'hF;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WR_ADDR_DATA = 3'd1,
      WR_RESP      = 3'd2,
      RD_ADDR      = 3'd3,
      RD_DATA      = 3'd4,
      RESP         = 3'd5
   } axil_state_t;

   // States in which the transaction is waiting on the bus and the stall counter runs
   function automatic logic state_is_busy(input axil_state_t s);
      return (s == WR_ADDR_DATA) || (s == WR_RESP) || (s == RD_ADDR) || (s == RD_DATA);
   endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - AXI4-Lite master turning a command stream into single write/read
// transactions with one response per command; all outputs registered.
module axil_cmd_master
   import axil_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [2:0]  AXI_PROT       = 3'b000
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,

   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_write,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,

   output logic        stall,

   output logic [31:0] M_AXI_AWADDR,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [2:0]  M_AXI_AWPROT,

   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,

   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,

   output logic [31:0] M_AXI_ARADDR,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   output logic [2:0]  M_AXI_ARPROT,

   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);

   axil_state_t state, state_n;

   logic        cmd_ready_n;
   logic        rsp_valid_n;
   logic        rsp_write_n;
   logic [31:0] rsp_rdata_n;
   logic [1:0]  rsp_resp_n;
   logic        awvalid_n;
   logic        wvalid_n;
   logic        bready_n;
   logic        arvalid_n;
   logic        rready_n;
   logic [31:0] awaddr_n;
   logic [31:0] wdata_n;
   logic [31:0] araddr_n;
   logic [31:0] wait_cnt, wait_cnt_n;
   logic        stall_n;
   logic        accept;
   logic        aw_done;
   logic        w_done;

   assign accept  = cmd_valid & cmd_ready;
   // A channel is finished once its VALID is already low or is being accepted this cycle
   assign aw_done = ~M_AXI_AWVALID | M_AXI_AWREADY;
   assign w_done  = ~M_AXI_WVALID  | M_AXI_WREADY;

   assign M_AXI_WSTRB  = WSTRB_ALL;
   assign M_AXI_AWPROT = AXI_PROT;
   assign M_AXI_ARPROT = AXI_PROT;

   always_comb begin
      state_n     = state;
      cmd_ready_n = cmd_ready;
      rsp_valid_n = rsp_valid;
      rsp_write_n = rsp_write;
      rsp_rdata_n = rsp_rdata;
      rsp_resp_n  = rsp_resp;
      awvalid_n   = M_AXI_AWVALID;
      wvalid_n    = M_AXI_WVALID;
      bready_n    = M_AXI_BREADY;
      arvalid_n   = M_AXI_ARVALID;
      rready_n    = M_AXI_RREADY;
      awaddr_n    = M_AXI_AWADDR;
      wdata_n     = M_AXI_WDATA;
      araddr_n    = M_AXI_ARADDR;

      case (state)
         IDLE: begin
            cmd_ready_n = 1'b1;
            if (accept) begin
               cmd_ready_n = 1'b0;
               rsp_write_n = cmd_write;
               if (cmd_addr[1:0] != 2'b00) begin
                  rsp_valid_n = 1'b1;
                  rsp_resp_n  = SLVERR;
                  rsp_rdata_n = 32'd0;
                  state_n     = RESP;
               end else if (cmd_write) begin
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                  awaddr_n  = cmd_addr;
                  wdata_n   = cmd_wdata;
                  state_n   = WR_ADDR_DATA;
               end else begin
                  arvalid_n = 1'b1;
                  araddr_n  = cmd_addr;
                  state_n   = RD_ADDR;
               end
            end
         end
         WR_ADDR_DATA: begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) awvalid_n = 1'b0;
            if (M_AXI_WVALID && M_AXI_WREADY)   wvalid_n  = 1'b0;
            if (aw_done && w_done) begin
               bready_n = 1'b1;
               state_n  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (M_AXI_BVALID && M_AXI_BREADY) begin
               bready_n    = 1'b0;
               rsp_resp_n  = M_AXI_BRESP;
               rsp_rdata_n = 32'd0;
               rsp_valid_n = 1'b1;
               state_n     = RESP;
            end
         end
         RD_ADDR: begin
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (M_AXI_RVALID && M_AXI_RREADY) begin
               rready_n    = 1'b0;
               rsp_rdata_n = M_AXI_RDATA;
               rsp_resp_n  = M_AXI_RRESP;
               rsp_valid_n = 1'b1;
               state_n     = RESP;
            end
         end
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               rsp_valid_n = 1'b0;
               cmd_ready_n = 1'b1;
               state_n     = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Saturating wait counter; stall is judged against the state being entered so it
   // drops on the same edge that rsp_valid rises
   always_comb begin
      wait_cnt_n = wait_cnt;
      if (state == IDLE && accept) begin
         wait_cnt_n = 32'd0;
      end else if (state_is_busy(state) && wait_cnt != 32'hFFFF_FFFF) begin
         wait_cnt_n = wait_cnt + 32'd1;
      end
      stall_n = (TIMEOUT_CYCLES != 0) && state_is_busy(state_n) && (wait_cnt_n >= TIMEOUT_CYCLES);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= IDLE;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_write     <= 1'b0;
         rsp_rdata     <= 32'd0;
         rsp_resp      <= 2'd0;
         stall         <= 1'b0;
         wait_cnt      <= 32'd0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         M_AXI_AWADDR  <= 32'd0;
         M_AXI_WDATA   <= 32'd0;
         M_AXI_ARADDR  <= 32'd0;
      end else begin
         state         <= state_n;
         cmd_ready     <= cmd_ready_n;
         rsp_valid     <= rsp_valid_n;
         rsp_write     <= rsp_write_n;
         rsp_rdata     <= rsp_rdata_n;
         rsp_resp      <= rsp_resp_n;
         stall         <= stall_n;
         wait_cnt      <= wait_cnt_n;
         M_AXI_AWVALID <= awvalid_n;
         M_AXI_WVALID  <= wvalid_n;
         M_AXI_BREADY  <= bready_n;
         M_AXI_ARVALID <= arvalid_n;
         M_AXI_RREADY  <= rready_n;
         M_AXI_AWADDR  <= awaddr_n;
         M_AXI_WDATA   <= wdata_n;
         M_AXI_ARADDR  <= araddr_n;
      end
   end

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - directed bench for axil_cmd_master against a delay-configurable
// AXI4-Lite slave model (16 regs at 0x00-0x3C, 0x3C answers EXOKAY, anything else DECERR).
module tb_axil_cmd_master;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        stall;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   axil_cmd_master #(.TIMEOUT_CYCLES(16), .AXI_PROT(3'b000)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .stall(stall),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWPROT(awprot),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARPROT(arprot),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else n_pass++;
   endtask

   // Slave model, evaluated on the falling edge so the DUT samples settled inputs
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
   int          valid_seen = 0, viol = 0, stall_drop = 0;
   int          cyc = 0, arv_rise = 0, stall_rise = 0;
   bit          aw_got, w_got, ar_got, b_fire, r_fire, arv_prev, stall_prev;
   logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
   logic [31:0] regs [16];

   function automatic logic [1:0] slv_resp(input logic [31:0] a);
      if (a[31:6] != 26'd0) return 2'd3;
      if (a[5:2] == 4'hF)   return 2'd1;
      return 2'd0;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!resetn) begin
         awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
         bresp = 0; rresp = 0; rdata = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
         aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
         arv_prev = 0; stall_prev = 0;
         for (int i = 0; i < 16; i++) regs[i] = 32'd0;
      end else begin
         if (awvalid || wvalid || arvalid) valid_seen++;
         if (aw_got && awvalid) viol++;
         if (w_got && wvalid) viol++;
         if (arvalid && !arv_prev) arv_rise = cyc;
         arv_prev = arvalid;
         if (stall && !stall_prev) stall_rise = cyc;
         if (stall_prev && !stall && !rsp_valid) stall_drop++;
         stall_prev = stall;

         if (b_fire) begin bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0; end
         if (r_fire) begin rvalid = 0; r_fire = 0; ar_got = 0; end

         if (aw_got && w_got && !bvalid && !b_fire) begin
            if (b_cnt >= b_delay) begin
               bvalid = 1; b_cnt = 0;
               bresp  = slv_resp(aw_addr_q);
               if (bresp != 2'd3) regs[aw_addr_q[5:2]] = w_data_q;
            end else b_cnt++;
         end
         if (bvalid && bready) begin b_fire = 1; b_hs++; end

         if (ar_got && !rvalid && !r_fire) begin
            if (r_cnt >= r_delay) begin
               rvalid = 1; r_cnt = 0;
               rresp  = slv_resp(ar_addr_q);
               rdata  = (rresp == 2'd3) ? 32'd0 : regs[ar_addr_q[5:2]];
            end else r_cnt++;
         end
         if (rvalid && rready) begin r_fire = 1; r_hs++; end

         awready = 0;
         if (awvalid && !aw_got) begin
            if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++;
         end
         if (awvalid && awready) begin aw_got = 1; aw_hs++; aw_addr_q = awaddr; aw_cnt = 0; end

         wready = 0;
         if (wvalid && !w_got) begin
            if (w_cnt >= w_delay) wready = 1; else w_cnt++;
         end
         if (wvalid && wready) begin w_got = 1; w_hs++; w_data_q = wdata; w_cnt = 0; end

         arready = 0;
         if (arvalid && !ar_got) begin
            if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++;
         end
         if (arvalid && arready) begin ar_got = 1; ar_hs++; ar_addr_q = araddr; ar_cnt = 0; end
      end
   end

   logic        last_stall;

   task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input int hold,
                         output logic [31:0] rd, output logic [1:0] resp, output logic rw,
                         output int lat, output int unstable);
      int n;
      @(negedge clk);
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      n = 0;
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      check("cmd_accepted", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 0;
      lat = 1;
      while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
      check("rsp_seen", 32'(rsp_valid), 32'd1);
      rd = rsp_rdata; resp = rsp_resp; rw = rsp_write; last_stall = stall;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (rsp_rdata !== rd || rsp_resp !== resp || rsp_write !== rw || !rsp_valid || cmd_ready)
            unstable++;
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      if (rsp_valid) unstable++;
   endtask

   logic [31:0] rd;
   logic [1:0]  resp;
   logic        rw;
   int          lat, uns, s_aw, s_w, s_b, s_v, s_viol, s_drop, n;
   int          aw_d [3] = '{5, 0, 0};
   int          w_d  [3] = '{0, 5, 0};

   initial begin
      resetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
      repeat (3) @(negedge clk);
      check("rst_handshakes", {cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready, stall}, 32'd0);
      check("rst_rsp_fields", {rsp_rdata[29:0], rsp_resp}, 32'd0);
      check("rst_rsp_write", 32'(rsp_write), 32'd0);
      check("wstrb_prot", {wstrb, awprot, arprot}, {4'hF, 6'd0} & 32'h3FF);
      resetn = 1;

      do_cmd(1, 32'h28, 32'h0040_0000, 0, rd, resp, rw, lat, uns);
      check("wr28_resp", resp, 0);
      check("wr28_write", rw, 1);
      check("wr28_latency", lat, 3);
      check("wr28_stall", last_stall, 0);
      do_cmd(0, 32'h28, 32'h0, 0, rd, resp, rw, lat, uns);
      check("rd28_resp", resp, 0);
      check("rd28_data", rd, 32'h0040_0000);
      check("rd28_write", rw, 0);
      check("rd28_latency", lat, 3);

      s_b = b_hs;
      do_cmd(1, 32'h50, 32'hDEAD_BEEF, 0, rd, resp, rw, lat, uns);
      check("wr50_resp", resp, 3);
      check("wr50_b_hs", b_hs - s_b, 1);
      do_cmd(0, 32'h50, 32'h0, 0, rd, resp, rw, lat, uns);
      check("rd50_resp", resp, 3);
      check("rd50_data", rd, 0);

      do_cmd(1, 32'h3C, 32'h0000_1234, 0, rd, resp, rw, lat, uns);
      check("wr3c_exokay", resp, 1);
      do_cmd(0, 32'h3C, 32'h0, 0, rd, resp, rw, lat, uns);
      check("rd3c_exokay", resp, 1);
      check("rd3c_data", rd, 32'h0000_1234);

      for (int k = 0; k < 3; k++) begin
         aw_delay = aw_d[k]; w_delay = w_d[k];
         s_aw = aw_hs; s_w = w_hs; s_viol = viol;
         do_cmd(1, 32'h10 + 32'(4 * k), 32'hA000_0000 + 32'(k), 0, rd, resp, rw, lat, uns);
         check($sformatf("dly%0d_aw_hs", k), aw_hs - s_aw, 1);
         check($sformatf("dly%0d_w_hs", k), w_hs - s_w, 1);
         check($sformatf("dly%0d_valid_after_hs", k), viol - s_viol, 0);
         check($sformatf("dly%0d_resp", k), resp, 0);
      end
      aw_delay = 0; w_delay = 0;
      do_cmd(0, 32'h14, 32'h0, 0, rd, resp, rw, lat, uns);
      check("dly_readback", rd, 32'hA000_0001);

      s_v = valid_seen;
      do_cmd(1, 32'h0000_0006, 32'h1111_2222, 0, rd, resp, rw, lat, uns);
      check("misal_latency", 32'(lat <= 2), 1);
      check("misal_resp", resp, 2);
      check("misal_rdata", rd, 0);
      check("misal_write_echo", rw, 1);
      check("misal_no_axi_valid", valid_seen - s_v, 0);

      r_delay = 40; s_drop = stall_drop;
      do_cmd(0, 32'h28, 32'h0, 0, rd, resp, rw, lat, uns);
      r_delay = 0;
      check("stall_rise_delay", stall_rise - arv_rise, 16);
      check("stall_no_early_drop", stall_drop - s_drop, 0);
      check("stall_clear_in_resp", last_stall, 0);
      check("stall_rdata", rd, 32'h0040_0000);
      check("stall_resp", resp, 0);

      do_cmd(0, 32'h28, 32'h0, 10, rd, resp, rw, lat, uns);
      check("hold_stable", uns, 0);
      check("hold_rdata", rd, 32'h0040_0000);

      b_delay = 20;
      @(negedge clk);
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h08; cmd_wdata = 32'h5555_AAAA;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      cmd_valid = 0;
      n = 0;
      while (!bready && n < 50) begin @(negedge clk); n++; end
      check("mid_reach_wr_resp", 32'(bready), 1);
      resetn = 0;
      @(negedge clk);
      check("mid_rst_outputs", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 0);
      resetn = 1; b_delay = 0;
      n = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (rsp_valid) n++; end
      check("mid_rst_no_rsp", n, 0);

      do_cmd(1, 32'h04, 32'hA5A5_0001, 0, rd, resp, rw, lat, uns);
      check("recover_wr_resp", resp, 0);
      do_cmd(0, 32'h04, 32'h0, 0, rd, resp, rw, lat, uns);
      check("recover_rd_data", rd, 32'hA5A5_0001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
